control_unit_pipelined: RTL and testbench

//  RV32I control unit for the 5-stage pipeline. Decodes op/funct3/funct7_5 in D; carries control through
//  E/M/W pipeline registers with stall/flush. Resolves branches and jumps in E from ALU flags, drives PCSrcE.

---
 rtl/control_unit_pipelined_pkg.sv | 95 +++++++++
 rtl/control_unit_pipelined_if.sv | 47 ++++
 rtl/control_unit_pipelined_branch.sv | 29 ++
 rtl/control_unit_pipelined.sv | 162 ++++++++++++++++
 tb/tb_control_unit_pipelined.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pipelined_pkg.sv
// Shared encodings and pipeline control bundles for the RV32I control unit.
package control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        jalr;
        alu_ctrl_e   alu_control;
        logic        alu_src;
        logic [2:0]  funct3;
        logic        illegal;
    } ctrl_e_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
    } ctrl_w_t;

    localparam ctrl_e_t CTRL_E_BUBBLE = '0;
    localparam ctrl_m_t CTRL_M_BUBBLE = '0;
    localparam ctrl_w_t CTRL_W_BUBBLE = '0;

    // funct7[5] selects SUB only for register-register adds; SRA/SRAI for either form.
    function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3,
                                             input logic       funct7_5,
                                             input logic       is_r);
        alu_ctrl_e op;
        case (funct3)
            3'b000:  op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit_pipelined_if.sv
// Decode inputs, hazard controls, ALU flags and per-stage control outputs of the control unit.
interface control_unit_pipelined_if #(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int IMM_SRC_WIDTH  = 3,
    parameter int STAT_WIDTH     = 32
);
    logic [OP_WIDTH-1:0]       opD;
    logic [FUNCT3_WIDTH-1:0]   funct3D;
    logic                      funct7_5D;
    logic                      StallE;
    logic                      FlushE;
    logic                      ZeroE;
    logic                      NE;
    logic                      CE;
    logic                      VE;
    logic [IMM_SRC_WIDTH-1:0]  ImmSrcD;
    logic [ALU_CTRL_WIDTH-1:0] ALUControlE;
    logic                      ALUSrcE;
    logic                      PCSrcE;
    logic                      JalrE;
    logic                      MemWriteM;
    logic                      RegWriteE;
    logic                      RegWriteM;
    logic                      RegWriteW;
    logic [1:0]                ResultSrcE;
    logic [1:0]                ResultSrcM;
    logic [1:0]                ResultSrcW;
    logic                      IllegalE;
    logic [STAT_WIDTH-1:0]     BranchCnt;
    logic [STAT_WIDTH-1:0]     TakenCnt;

    modport slave (
        input  opD, funct3D, funct7_5D, StallE, FlushE, ZeroE, NE, CE, VE,
        output ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, JalrE, MemWriteM,
               RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
               IllegalE, BranchCnt, TakenCnt
    );

    modport master (
        output opD, funct3D, funct7_5D, StallE, FlushE, ZeroE, NE, CE, VE,
        input  ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, JalrE, MemWriteM,
               RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
               IllegalE, BranchCnt, TakenCnt
    );
endinterface

// File: rtl/control_unit_pipelined_branch.sv
// E-stage branch/jump resolution from the rs1-rs2 compare flags.
module branch_unit
    import control_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    input  logic       carry,
    input  logic       ovf,
    input  logic       branch,
    input  logic       jump,
    output logic       pc_src
);
    logic cond;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = ~zero;
            F3_BLT:  cond = neg ^ ovf;
            F3_BGE:  cond = ~(neg ^ ovf);
            F3_BLTU: cond = ~carry;
            F3_BGEU: cond = carry;
            default: cond = 1'b0;
        endcase
        pc_src = jump | (branch & cond);
    end
endmodule

// File: rtl/control_unit_pipelined.sv
// RV32I pipelined control unit: D decode, E/M/W control registers, E-stage redirect.
// Optional branch statistics counters built when BRANCH_STATS_EN is defined.
module control_unit_pipelined
    import control_pkg::*;
#(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int IMM_SRC_WIDTH  = 3,
    parameter int STAT_WIDTH     = 32
) (
    input logic                     clk,
    input logic                     rst,
    control_unit_pipelined_if.slave bus
);
    logic [OP_WIDTH-1:0]     op_d;
    logic [FUNCT3_WIDTH-1:0] funct3_d;
    imm_src_e                imm_src;
    ctrl_e_t                 dec;
    ctrl_e_t                 e_q;
    ctrl_m_t                 m_q;
    ctrl_w_t                 w_q;
    logic                    pc_src;

    assign op_d     = bus.opD;
    assign funct3_d = bus.funct3D;

    always_comb begin
        dec        = CTRL_E_BUBBLE;
        imm_src    = IMM_I;
        dec.funct3 = funct3_d;
        case (op_d)
            OP_R: begin
                dec.reg_write   = 1'b1;
                dec.alu_control = alu_decode(funct3_d, bus.funct7_5D, 1'b1);
            end
            OP_IMM: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = alu_decode(funct3_d, bus.funct7_5D, 1'b0);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                imm_src       = IMM_S;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                imm_src = IMM_B;
                if (funct3_d == 3'b010 || funct3_d == 3'b011) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.branch      = 1'b1;
                    dec.alu_control = ALU_SUB;
                end
            end
            OP_JAL: begin
                imm_src        = IMM_J;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
            end
            OP_LUI: begin
                imm_src         = IMM_U;
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_PASSB;
            end
            OP_AUIPC: begin
                imm_src       = IMM_U;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Flush wins over stall: a redirect or load-use bubble must not be held.
    always_ff @(posedge clk) begin
        if (rst || bus.FlushE) begin
            e_q <= CTRL_E_BUBBLE;
        end else if (!bus.StallE) begin
            e_q <= dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.StallE) begin
            m_q <= CTRL_M_BUBBLE;
        end else begin
            m_q <= '{reg_write: e_q.reg_write, result_src: e_q.result_src,
                     mem_write: e_q.mem_write};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= CTRL_W_BUBBLE;
        end else begin
            w_q <= '{reg_write: m_q.reg_write, result_src: m_q.result_src};
        end
    end

    branch_unit u_branch (
        .funct3 (e_q.funct3),
        .zero   (bus.ZeroE),
        .neg    (bus.NE),
        .carry  (bus.CE),
        .ovf    (bus.VE),
        .branch (e_q.branch),
        .jump   (e_q.jump),
        .pc_src (pc_src)
    );

    assign bus.ImmSrcD     = IMM_SRC_WIDTH'(imm_src);
    assign bus.ALUControlE = ALU_CTRL_WIDTH'(e_q.alu_control);
    assign bus.ALUSrcE     = e_q.alu_src;
    assign bus.PCSrcE      = pc_src;
    assign bus.JalrE       = e_q.jalr;
    assign bus.IllegalE    = e_q.illegal;
    assign bus.RegWriteE   = e_q.reg_write;
    assign bus.ResultSrcE  = e_q.result_src;
    assign bus.MemWriteM   = m_q.mem_write;
    assign bus.RegWriteM   = m_q.reg_write;
    assign bus.ResultSrcM  = m_q.result_src;
    assign bus.RegWriteW   = w_q.reg_write;
    assign bus.ResultSrcW  = w_q.result_src;

`ifdef BRANCH_STATS_EN
    logic [STAT_WIDTH-1:0] branch_cnt;
    logic [STAT_WIDTH-1:0] taken_cnt;

    // A stalled branch is counted once, on the edge that releases it from E.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (e_q.branch && !bus.StallE) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + STAT_WIDTH'(1);
            if (pc_src && taken_cnt != '1) taken_cnt <= taken_cnt + STAT_WIDTH'(1);
        end
    end

    assign bus.BranchCnt = branch_cnt;
    assign bus.TakenCnt  = taken_cnt;
`else
    assign bus.BranchCnt = {STAT_WIDTH{1'b0}};
    assign bus.TakenCnt  = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Self-checking bench for control_unit_pipelined against an instruction-level pipeline model.
module tb_control_unit_pipelined;
    import control_pkg::*;

    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    typedef struct packed {
        logic       valid;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
    } instr_t;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic [1:0] rs;
        logic [3:0] alu;
        logic       alusrc;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic       illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_unit_pipelined_if #(.OP_WIDTH(7), .FUNCT3_WIDTH(3), .ALU_CTRL_WIDTH(4),
                                .IMM_SRC_WIDTH(3), .STAT_WIDTH(SW)) bus ();

    control_unit_pipelined #(.OP_WIDTH(7), .FUNCT3_WIDTH(3), .ALU_CTRL_WIDTH(4),
                             .IMM_SRC_WIDTH(3), .STAT_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    instr_t     mE = '0;
    exp_t       mM = '0;
    exp_t       mW = '0;
    int         bc = 0;
    int         tc = 0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0] alu_by_f3 [8];
    logic [6:0] op_tab [10];

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] r;
        r = alu_by_f3[f3];
        if (f3 == 3'd0 && is_r && f7) r = ALU_SUB;
        if (f3 == 3'd5 && f7) r = ALU_SRA;
        return r;
    endfunction

    function automatic exp_t ref_ctrl(input instr_t i);
        exp_t x;
        x = '0;
        if (!i.valid) return x;
        case (i.op)
            7'b0110011: begin x.rw = 1; x.alu = ref_alu(i.f3, i.f7, 1'b1); end
            7'b0010011: begin x.rw = 1; x.alusrc = 1; x.alu = ref_alu(i.f3, i.f7, 1'b0); end
            7'b0000011: begin x.rw = 1; x.alusrc = 1; x.rs = 2'b01; x.alu = ALU_ADD; end
            7'b0100011: begin x.mw = 1; x.alusrc = 1; x.alu = ALU_ADD; end
            7'b1100011: begin
                if (i.f3 == 3'd2 || i.f3 == 3'd3) x.illegal = 1;
                else begin x.branch = 1; x.alu = ALU_SUB; end
            end
            7'b1101111: begin x.rw = 1; x.rs = 2'b10; x.jump = 1; end
            7'b1100111: begin x.rw = 1; x.rs = 2'b10; x.jump = 1; x.jalr = 1; x.alusrc = 1; end
            7'b0110111: begin x.rw = 1; x.alusrc = 1; x.alu = ALU_PASSB; end
            7'b0010111: begin x.rw = 1; x.alusrc = 1; x.alu = ALU_ADD; end
            default:    x.illegal = 1;
        endcase
        return x;
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'(IMM_S);
            7'b1100011:             return 3'(IMM_B);
            7'b1101111:             return 3'(IMM_J);
            7'b0110111, 7'b0010111: return 3'(IMM_U);
            default:                return 3'(IMM_I);
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd4:    return $signed(x) < $signed(y);
            3'd5:    return $signed(x) >= $signed(y);
            3'd6:    return x < y;
            3'd7:    return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    endtask

    task automatic set_flags(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] d;
        a = x;
        b = y;
        d = {1'b0, x} + {1'b0, ~y} + 33'd1;
        bus.ZeroE = (x == y);
        bus.CE    = d[32];
        bus.NE    = d[31];
        bus.VE    = (x[31] ^ y[31]) & (d[31] ^ x[31]);
    endtask

    task automatic check_all(input string tag);
        exp_t e;
        logic pc;
        e  = ref_ctrl(mE);
        pc = e.jump | (e.branch & ref_taken(mE.f3, a, b));
        chk({tag, "/ImmSrcD"},     32'(bus.ImmSrcD),     32'(ref_imm(bus.opD)));
        chk({tag, "/ALUControlE"}, 32'(bus.ALUControlE), 32'(e.alu));
        chk({tag, "/ALUSrcE"},     32'(bus.ALUSrcE),     32'(e.alusrc));
        chk({tag, "/PCSrcE"},      32'(bus.PCSrcE),      32'(pc));
        chk({tag, "/JalrE"},       32'(bus.JalrE),       32'(e.jalr));
        chk({tag, "/IllegalE"},    32'(bus.IllegalE),    32'(e.illegal));
        chk({tag, "/RegWriteE"},   32'(bus.RegWriteE),   32'(e.rw));
        chk({tag, "/ResultSrcE"},  32'(bus.ResultSrcE),  32'(e.rs));
        chk({tag, "/MemWriteM"},   32'(bus.MemWriteM),   32'(mM.mw));
        chk({tag, "/RegWriteM"},   32'(bus.RegWriteM),   32'(mM.rw));
        chk({tag, "/ResultSrcM"},  32'(bus.ResultSrcM),  32'(mM.rs));
        chk({tag, "/RegWriteW"},   32'(bus.RegWriteW),   32'(mW.rw));
        chk({tag, "/ResultSrcW"},  32'(bus.ResultSrcW),  32'(mW.rs));
`ifdef BRANCH_STATS_EN
        chk({tag, "/BranchCnt"},   32'(bus.BranchCnt),   32'(bc));
        chk({tag, "/TakenCnt"},    32'(bus.TakenCnt),    32'(tc));
`else
        chk({tag, "/BranchCnt"},   32'(bus.BranchCnt),   32'd0);
        chk({tag, "/TakenCnt"},    32'(bus.TakenCnt),    32'd0);
`endif
    endtask

    // One clock: drive D and hazard controls, advance the model, then present new flags for E.
    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic st, input logic fl, input logic r,
                        input logic [31:0] na, input logic [31:0] nb);
        exp_t ce;
        bus.opD = op; bus.funct3D = f3; bus.funct7_5D = f7;
        bus.StallE = st; bus.FlushE = fl; rst = r;
        ce = ref_ctrl(mE);
        if (r) begin
            bc = 0; tc = 0;
        end else if (ce.branch && !st) begin
            if (bc < SMAX) bc++;
            if (ref_taken(mE.f3, a, b) && tc < SMAX) tc++;
        end
        @(posedge clk);
        #1;
        if (r) begin
            mW = '0; mM = '0; mE = '0;
        end else begin
            mW = mM;
            mM = st ? '0 : ce;
            if (fl) mE = '0;
            else if (!st) mE = '{valid: 1'b1, op: op, f3: f3, f7: f7};
        end
        set_flags(na, nb);
        #1;
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic [2:0]  bf3 [6];
        logic [31:0] ra;

        alu_by_f3 = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        op_tab = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h7F};
        pa  = '{32'd5, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        pb  = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        bus.opD = OP_R; bus.funct3D = '0; bus.funct7_5D = 1'b0;
        bus.StallE = 1'b0; bus.FlushE = 1'b0;
        set_flags('0, '0);

        step("reset0", OP_R, 3'd0, 1'b0, 0, 0, 1, 0, 0);
        step("reset1", OP_R, 3'd0, 1'b0, 0, 0, 1, 0, 0);

        step("add", OP_R, 3'd0, 1'b0, 0, 0, 0, 1, 2);
        step("sub", OP_R, 3'd0, 1'b1, 0, 0, 0, 1, 2);
        step("srai", OP_IMM, 3'd5, 1'b1, 0, 0, 0, 1, 2);
        step("addi_f7", OP_IMM, 3'd0, 1'b1, 0, 0, 0, 1, 2);
        step("nop", OP_IMM, 3'd0, 1'b0, 0, 0, 0, 1, 2);

        foreach (bf3[i]) begin
            for (int k = 0; k < 4; k++) step("branch", OP_BRANCH, bf3[i], 1'b0, 0, 0, 0, pa[k], pb[k]);
        end
        step("branch_f3_2", OP_BRANCH, 3'd2, 1'b0, 0, 0, 0, 5, 5);

        step("lw", OP_LOAD, 3'd2, 1'b0, 0, 0, 0, 0, 0);
        step("lw_stall", OP_IMM, 3'd0, 1'b0, 1, 0, 0, 0, 0);
        step("jal_in_e", OP_JAL, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        step("flush_stall", OP_IMM, 3'd0, 1'b0, 1, 1, 0, 0, 0);
        step("nop2", OP_IMM, 3'd0, 1'b0, 0, 0, 0, 0, 0);

        step("illegal", 7'b1111111, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        step("jalr", OP_JALR, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        step("store", OP_STORE, 3'd2, 1'b0, 0, 0, 0, 0, 0);
        step("lui", OP_LUI, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        step("auipc", OP_AUIPC, 3'd0, 1'b0, 0, 0, 0, 0, 0);

        // Twenty beq retire from E; the first seven see equal operands.
        step("stats_rst", OP_R, 3'd0, 1'b0, 0, 0, 1, 0, 0);
        for (int i = 0; i <= 20; i++) begin
            if (i < 7) step("stats", (i < 20) ? OP_BRANCH : OP_IMM, 3'd0, 1'b0, 0, 0, 0, 3, 3);
            else       step("stats", (i < 20) ? OP_BRANCH : OP_IMM, 3'd0, 1'b0, 0, 0, 0, 1, 2);
        end
`ifdef BRANCH_STATS_EN
        chk("stats_final/BranchCnt", 32'(bus.BranchCnt), 32'd15);
        chk("stats_final/TakenCnt",  32'(bus.TakenCnt),  32'd7);
`else
        chk("stats_final/BranchCnt", 32'(bus.BranchCnt), 32'd0);
        chk("stats_final/TakenCnt",  32'(bus.TakenCnt),  32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [6:0] rop;
            rop = op_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) rop = 7'($urandom);
            ra = $urandom;
            step("rand", rop, 3'($urandom), 1'($urandom),
                 $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                 ra, ($urandom_range(0, 3) == 0) ? ra : $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
